// File: rtl/mmio_pkg.sv
// Shared constants and register decode for the MIPS MMIO bridge.
package mmio_pkg;

  localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;

  localparam logic [7:0] MMIO_GPIO   = 8'h00;
  localparam logic [7:0] MMIO_TCOUNT = 8'h04;
  localparam logic [7:0] MMIO_TCMP   = 8'h08;
  localparam logic [7:0] MMIO_STATUS = 8'h0C;
  localparam logic [7:0] MMIO_TXDATA = 8'h10;

  localparam int unsigned ST_MATCH = 0;
  localparam int unsigned ST_FULL  = 1;
  localparam int unsigned ST_EMPTY = 2;
  localparam int unsigned ST_OVF   = 3;

  typedef enum logic [2:0] {
    RegGpio,
    RegTcount,
    RegTcmp,
    RegStatus,
    RegTxdata,
    RegNone
  } mmio_reg_e;

  // Decode on the word index; byte-lane bits are ignored.
  function automatic mmio_reg_e mmio_decode(input logic [5:0] word);
    mmio_reg_e reg_sel;
    case (word)
      MMIO_GPIO[7:2]:   reg_sel = RegGpio;
      MMIO_TCOUNT[7:2]: reg_sel = RegTcount;
      MMIO_TCMP[7:2]:   reg_sel = RegTcmp;
      MMIO_STATUS[7:2]: reg_sel = RegStatus;
      MMIO_TXDATA[7:2]: reg_sel = RegTxdata;
      default:          reg_sel = RegNone;
    endcase
    return reg_sel;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Byte TX FIFO: circular buffer with extra-MSB pointers, registered head (no fall-through).
module tx_fifo #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_push,
  input  logic [7:0]                    i_push_data,
  input  logic                          i_pop,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic [7:0]                    o_head,
  output logic                          o_overflow_pulse
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

  logic [7:0] r_mem [FIFO_DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        w_pop;
  logic        w_push_ok;

  assign o_count = r_wptr - r_rptr;
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (o_count == DEPTH_CNT);

  assign w_pop            = i_pop & ~o_empty;
  // A pop frees the slot being written, so a full push is still accepted.
  assign w_push_ok        = i_push & (~o_full | w_pop);
  assign o_overflow_pulse = i_push & o_full & ~w_pop;

  assign o_head = o_empty ? 8'h00 : r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/mmio_bridge.sv
// Address decoder plus GPIO, compare timer and TX FIFO behind the multicycle MIPS memory port.
// Define MMIO_TIMER_EN to build the timer, TCOUNT/TCMP registers and irq.
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMER_DIV  = 1,
  parameter int unsigned RAM_AW     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] adr,
  input  logic [31:0] writedata,
  input  logic        memwrite,
  output logic [31:0] readdata,
  output logic [31:0] ram_adr,
  output logic [31:0] ram_wd,
  output logic        ram_we,
  input  logic [31:0] ram_rd,
  output logic [31:0] gpio_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        irq
);

  localparam int unsigned FIFO_AW = $clog2(FIFO_DEPTH);

  logic            w_ram_sel;
  logic            w_mmio_sel;
  mmio_reg_e       w_reg;
  logic            w_wr_gpio;
  logic            w_wr_status;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic            w_ovf_pulse;
  logic [FIFO_AW:0] w_fifo_count;
  logic [31:0]     w_status;
  logic [31:0]     w_tcount;
  logic [31:0]     w_tcmp;
  logic            w_match;

  logic [31:0]     r_gpio;
  logic            r_ovf;
  logic            w_ovf_d;

  assign w_ram_sel  = ((adr >> RAM_AW) == 32'h0);
  assign w_mmio_sel = (adr[31:8] == MMIO_BASE[31:8]);
  assign w_reg      = w_mmio_sel ? mmio_decode(adr[7:2]) : RegNone;

  assign ram_adr = adr;
  assign ram_wd  = writedata;
  assign ram_we  = memwrite & w_ram_sel;

  assign w_wr_gpio   = memwrite & (w_reg == RegGpio);
  assign w_wr_status = memwrite & (w_reg == RegStatus);
  assign w_push      = memwrite & (w_reg == RegTxdata);
  assign w_pop       = tx_valid & tx_ready;

  tx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_tx_fifo (
    .clk              (clk),
    .reset            (reset),
    .i_push           (w_push),
    .i_push_data      (writedata[7:0]),
    .i_pop            (w_pop),
    .o_full           (w_full),
    .o_empty          (w_empty),
    .o_count          (w_fifo_count),
    .o_head           (tx_data),
    .o_overflow_pulse (w_ovf_pulse)
  );

  assign tx_valid = ~w_empty;

  // Overflow set has priority over a software clear in the same cycle.
  always_comb begin
    w_ovf_d = r_ovf;
    if (w_wr_status && writedata[ST_OVF]) w_ovf_d = 1'b0;
    if (w_ovf_pulse)                      w_ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gpio <= 32'h0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_wr_gpio) r_gpio <= writedata;
      r_ovf <= w_ovf_d;
    end
  end

  assign gpio_out = r_gpio;

`ifdef MMIO_TIMER_EN
  localparam logic [31:0] PRESC_LAST = 32'(TIMER_DIV - 1);

  logic [31:0] r_presc;
  logic [31:0] r_tcount;
  logic [31:0] r_tcmp;
  logic        r_match;
  logic [31:0] w_presc_d;
  logic [31:0] w_tcount_d;
  logic [31:0] w_tcmp_d;
  logic        w_match_d;
  logic        w_tcount_upd;
  logic        w_wr_tcount;
  logic        w_wr_tcmp;

  assign w_wr_tcount = memwrite & (w_reg == RegTcount);
  assign w_wr_tcmp   = memwrite & (w_reg == RegTcmp);

  always_comb begin
    w_presc_d    = r_presc;
    w_tcount_d   = r_tcount;
    w_tcount_upd = 1'b0;
    w_tcmp_d     = w_wr_tcmp ? writedata : r_tcmp;
    if (w_wr_tcount) begin
      w_tcount_d   = writedata;
      w_presc_d    = 32'h0;
      w_tcount_upd = 1'b1;
    end else if (r_presc == PRESC_LAST) begin
      w_tcount_d   = r_tcount + 32'h1;
      w_presc_d    = 32'h0;
      w_tcount_upd = 1'b1;
    end else begin
      w_presc_d = r_presc + 32'h1;
    end
    // Match only fires when TCOUNT actually changes; the set beats a same-cycle clear.
    w_match_d = r_match;
    if (w_wr_status && writedata[ST_MATCH])    w_match_d = 1'b0;
    if (w_tcount_upd && (w_tcount_d == r_tcmp)) w_match_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc  <= 32'h0;
      r_tcount <= 32'h0;
      r_tcmp   <= 32'hFFFF_FFFF;
      r_match  <= 1'b0;
    end else begin
      r_presc  <= w_presc_d;
      r_tcount <= w_tcount_d;
      r_tcmp   <= w_tcmp_d;
      r_match  <= w_match_d;
    end
  end

  assign w_tcount = r_tcount;
  assign w_tcmp   = r_tcmp;
  assign w_match  = r_match;
`else
  assign w_tcount = 32'h0;
  assign w_tcmp   = 32'h0;
  assign w_match  = 1'b0;
`endif

  assign irq = w_match;

  always_comb begin
    w_status           = 32'h0;
    w_status[ST_MATCH] = w_match;
    w_status[ST_FULL]  = w_full;
    w_status[ST_EMPTY] = w_empty;
    w_status[ST_OVF]   = r_ovf;
  end

  always_comb begin
    readdata = 32'h0;
    if (w_ram_sel) begin
      readdata = ram_rd;
    end else begin
      case (w_reg)
        RegGpio:   readdata = r_gpio;
        RegTcount: readdata = w_tcount;
        RegTcmp:   readdata = w_tcmp;
        RegStatus: readdata = w_status;
        RegTxdata: readdata = 32'(w_fifo_count);
        default:   readdata = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_bridge.sv
// Self-checking bench for mmio_bridge; TX bytes are tracked by a scoreboard queue.
module tb_mmio_bridge;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] A_GPIO   = 32'hFFFF_0000;
  localparam logic [31:0] A_TCOUNT = 32'hFFFF_0004;
  localparam logic [31:0] A_TCMP   = 32'hFFFF_0008;
  localparam logic [31:0] A_STATUS = 32'hFFFF_000C;
  localparam logic [31:0] A_TXDATA = 32'hFFFF_0010;

  logic        clk;
  logic        reset;
  logic [31:0] adr;
  logic [31:0] writedata;
  logic        memwrite;
  logic [31:0] readdata;
  logic [31:0] ram_adr;
  logic [31:0] ram_wd;
  logic        ram_we;
  logic [31:0] ram_rd;
  logic [31:0] gpio_out;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        irq;

  int n_tests;
  int n_fail;

  logic [7:0]  q[$];
  logic        push_pend;
  logic [7:0]  push_byte;
  logic        m_ovf;
  logic [31:0] tb_ram [256];

  mmio_bridge #(
    .FIFO_DEPTH(DEPTH),
    .TIMER_DIV (1),
    .RAM_AW    (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .adr      (adr),
    .writedata(writedata),
    .memwrite (memwrite),
    .readdata (readdata),
    .ram_adr  (ram_adr),
    .ram_wd   (ram_wd),
    .ram_we   (ram_we),
    .ram_rd   (ram_rd),
    .gpio_out (gpio_out),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  assign ram_rd = tb_ram[ram_adr[9:2]];

  always @(posedge clk) begin
    if (ram_we) tb_ram[ram_adr[9:2]] <= ram_wd;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] status_exp();
    logic [31:0] s;
    s    = 32'h0;
    s[1] = (q.size() == DEPTH);
    s[2] = (q.size() == 0);
    s[3] = m_ovf;
    return s;
  endfunction

  // One clock: check the TX head against the scoreboard, then retire pop/push at the edge.
  task automatic cycle();
    logic pop;
    logic accept;
    #1;
    check_eq("tx_valid", 32'(tx_valid), 32'(q.size() != 0));
    if (q.size() != 0) check_eq("tx_data", 32'(tx_data), 32'(q[0]));
    pop    = tx_ready && (q.size() != 0);
    accept = push_pend && ((q.size() != DEPTH) || pop);
    if (push_pend && !accept) m_ovf = 1'b1;
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    if (accept) q.push_back(push_byte);
    push_pend = 1'b0;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    adr       = a;
    writedata = d;
    memwrite  = 1'b1;
    if (a == A_TXDATA) begin
      push_pend = 1'b1;
      push_byte = d[7:0];
    end
    if (a == A_STATUS && d[3]) m_ovf = 1'b0;
    cycle();
    memwrite = 1'b0;
  endtask

  task automatic bus_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    adr      = a;
    memwrite = 1'b0;
    #1;
    check_eq(tag, readdata, exp);
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] fill_a [5];
    logic [7:0] fill_b [4];
    fill_a = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    fill_b = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    for (int i = 0; i < 256; i++) tb_ram[i] = 32'h5A5A_5A5A;
    n_tests   = 0;
    n_fail    = 0;
    clk       = 1'b0;
    reset     = 1'b1;
    adr       = 32'h0;
    writedata = 32'h0;
    memwrite  = 1'b0;
    tx_ready  = 1'b0;
    push_pend = 1'b0;
    push_byte = 8'h0;
    m_ovf     = 1'b0;

    // Reset state
    #2;
    check_eq("rst_gpio", gpio_out, 32'h0);
    check_eq("rst_tx_valid", 32'(tx_valid), 32'h0);
    check_eq("rst_tx_data", 32'(tx_data), 32'h0);
    check_eq("rst_irq", 32'(irq), 32'h0);
    adr = A_STATUS;
    #1;
    check_eq("rst_status", readdata, 32'h4);
    adr = A_TCMP;
    #1;
`ifdef MMIO_TIMER_EN
    check_eq("rst_tcmp", readdata, 32'hFFFF_FFFF);
`else
    check_eq("rst_tcmp", readdata, 32'h0);
`endif
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // RAM passthrough
    adr       = 32'h0000_0040;
    writedata = 32'hDEAD_BEEF;
    memwrite  = 1'b1;
    #1;
    check_eq("ram_we_hi", 32'(ram_we), 32'h1);
    check_eq("ram_adr", ram_adr, 32'h0000_0040);
    check_eq("ram_wd", ram_wd, 32'hDEAD_BEEF);
    cycle();
    memwrite = 1'b0;
    #1;
    check_eq("ram_we_lo", 32'(ram_we), 32'h0);
    bus_rd("ram_load", 32'h0000_0040, 32'hDEAD_BEEF);
    bus_rd("ram_unmapped", 32'h0002_0000, 32'h0);

    // GPIO, unmapped MMIO, then asynchronous reset mid-cycle
    bus_wr(A_GPIO, 32'h0000_00A5);
    check_eq("gpio_out", gpio_out, 32'h0000_00A5);
    bus_rd("gpio_rd", A_GPIO, 32'h0000_00A5);
    bus_wr(32'hFFFF_0024, 32'h1234_5678);
    bus_rd("unmapped_rd", 32'hFFFF_0024, 32'h0);
    bus_rd("gpio_kept", A_GPIO, 32'h0000_00A5);
    bus_wr(A_TXDATA, 32'h0000_0077);
    reset = 1'b1;
    #1;
    check_eq("arst_gpio", gpio_out, 32'h0);
    check_eq("arst_tx_valid", 32'(tx_valid), 32'h0);
    check_eq("arst_tx_data", 32'(tx_data), 32'h0);
    q.delete();
    m_ovf = 1'b0;
    #1;
    reset = 1'b0;
    cycle();

`ifdef MMIO_TIMER_EN
    bus_wr(A_TCMP, 32'd10);
    bus_wr(A_TCOUNT, 32'd0);
    repeat (9) cycle();
    check_eq("irq_early", 32'(irq), 32'h0);
    cycle();
    check_eq("irq_match", 32'(irq), 32'h1);
    bus_rd("status_match", A_STATUS, 32'h5);
    bus_wr(A_STATUS, 32'h1);
    check_eq("irq_clr", 32'(irq), 32'h0);
    bus_wr(A_TCMP, 32'h8000_0000);
    bus_wr(A_TCOUNT, 32'hFFFF_FFFF);
    bus_rd("tcount_max", A_TCOUNT, 32'hFFFF_FFFF);
    bus_rd("tcount_wrap", A_TCOUNT, 32'h0);
`else
    bus_wr(A_TCOUNT, 32'd5);
    bus_rd("tcount_off", A_TCOUNT, 32'h0);
    bus_wr(A_TCMP, 32'd3);
    bus_rd("tcmp_off", A_TCMP, 32'h0);
    for (int i = 0; i < 100; i++) begin
      cycle();
      check_eq("irq_off", 32'(irq), 32'h0);
    end
`endif

    // FIFO fill past full with the consumer stalled
    tx_ready = 1'b0;
    foreach (fill_a[i]) bus_wr(A_TXDATA, {24'h0, fill_a[i]});
    bus_rd("status_full_ovf", A_STATUS, status_exp());
    bus_rd("count_full", A_TXDATA, 32'(q.size()));
    bus_wr(A_STATUS, 32'h0000_0006);
    bus_rd("status_ro", A_STATUS, status_exp());
    tx_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) cycle();
    if (q.size() != 0) check_eq("drain_a_timeout", 32'(q.size()), 32'h0);
    repeat (3) cycle();

    // Full push with a simultaneous pop is accepted without overflow
    bus_wr(A_STATUS, 32'h0000_0008);
    bus_rd("status_ovf_clr", A_STATUS, status_exp());
    tx_ready = 1'b0;
    foreach (fill_b[i]) bus_wr(A_TXDATA, {24'h0, fill_b[i]});
    tx_ready = 1'b1;
    bus_wr(A_TXDATA, 32'h0000_0066);
    tx_ready = 1'b0;
    bus_rd("count_push_pop", A_TXDATA, 32'(q.size()));
    bus_rd("status_push_pop", A_STATUS, status_exp());
    tx_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) cycle();
    if (q.size() != 0) check_eq("drain_b_timeout", 32'(q.size()), 32'h0);
    repeat (2) cycle();
    bus_rd("status_end", A_STATUS, status_exp());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_bridge.md
Name: mmio_bridge

Overview:
- Address decoder and memory-mapped I/O block sitting directly downstream of the multicycle MIPS core's memory port (adr, writedata, memwrite, readdata).
- Routes core accesses either to the unified instruction/data RAM or to a small peripheral register set.
- Peripherals: a GPIO output register, a compare timer with an interrupt, and a byte TX FIFO that feeds a downstream serializer over a valid/ready handshake.
- readdata is combinational from adr, so the core's instruction and data registers capture it at the next clock edge exactly as with plain RAM.

Parameters:
- FIFO_DEPTH, 4, TX FIFO entries; must be a power of two, at least 2.
- TIMER_DIV, 1, core cycles per timer increment; 1 means the timer increments every cycle.
- RAM_AW, 16, RAM byte-address width; RAM is selected when adr[31:RAM_AW] == 0.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- adr  in  32  core byte address
- writedata  in  32  core store data
- memwrite  in  1  core store strobe, single cycle
- readdata  out  32  load/fetch data to core, combinational
- ram_adr  out  32  RAM address; passthrough of adr
- ram_wd  out  32  RAM write data; passthrough of writedata
- ram_we  out  1  memwrite AND ram_sel
- ram_rd  in  32  RAM read data
- gpio_out  out  32  GPIO register
- tx_data  out  8  FIFO head byte
- tx_valid  out  1  FIFO not empty
- tx_ready  in  1  downstream accepts tx_data
- irq  out  1  timer match flag, level-sensitive

Behaviour:
- Decode is combinational. ram_sel = (adr[31:RAM_AW] == 0). mmio_sel = (adr[31:8] == 24'hFFFF00).
- Register map (word offsets, adr[1:0] ignored):
  - 0x00 GPIO (read/write).
  - 0x04 TCOUNT (read/write).
  - 0x08 TCMP (read/write).
  - 0x0C STATUS (read): bit0 match, bit1 full, bit2 empty, bit3 overflow. Writing 1 to bit0 or bit3 clears that bit.
  - 0x10 TXDATA: write pushes writedata[7:0]; read returns the FIFO occupancy count, zero-extended.
- Reads: ram_sel returns ram_rd. A mapped MMIO offset returns its register. Anything else returns 32'h0.
- Writes: writes to unmapped addresses and to read-only bits are ignored with no side effects. MMIO writes take effect at the clock edge where memwrite is high.
- Reset values: gpio_out 0, TCOUNT 0, TCMP 32'hFFFF_FFFF, prescaler 0, match 0, overflow 0, FIFO empty (tx_valid 0, tx_data 0), irq 0. Reset is asynchronous and may abort a transaction mid-instruction; all state returns to reset values immediately.
- Timer:
  - A prescaler counts 0 to TIMER_DIV-1. TCOUNT increments by 1 on the prescaler's terminal cycle and wraps from FFFF_FFFF to 0.
  - A TCOUNT write overrides the increment that cycle and resets the prescaler.
  - match is set on the edge at which the updated TCOUNT equals TCMP.
  - If a set and a clear of match occur in the same cycle, the set wins.
  - irq equals match.
- TX FIFO:
  - Circular buffer with log2(FIFO_DEPTH)+1-bit read and write pointers; the pointers wrap.
  - Pop happens when tx_valid and tx_ready are both high.
  - A push while full with no pop in the same cycle is dropped and sets overflow.
  - A push while full with a pop in the same cycle is accepted; occupancy stays at FIFO_DEPTH.
  - When empty, a push is visible on tx_valid/tx_data on the following cycle; there is no fall-through.
  - tx_data is stable while tx_valid is high and tx_ready is low.
- Latency: loads are 0 cycles (combinational); register updates are 1 cycle.

Optional Feature:
- Macro: MMIO_TIMER_EN.
- Defined: timer, prescaler, TCOUNT, TCMP, the match bit and irq are implemented as specified above.
- Undefined: no timer logic is generated. TCOUNT and TCMP read as 0 and writes to them are ignored. STATUS bit0 reads 0. irq is tied to 0.

Decomposition:
- Package mmio_pkg holds:
  - Offset constants MMIO_GPIO, MMIO_TCOUNT, MMIO_TCMP, MMIO_STATUS, MMIO_TXDATA.
  - MMIO_BASE = 32'hFFFF_0000.
  - STATUS bit-index constants ST_MATCH, ST_FULL, ST_EMPTY, ST_OVF.
- One sub-module, tx_fifo, parameterized by FIFO_DEPTH. It exposes push, push_data, pop, full, empty, count, head and overflow_pulse.
- Timer and decode stay in mmio_bridge.

Test Plan:
- RAM passthrough: store 32'hDEADBEEF to adr 0x0040, then load from 0x0040 → ram_we high for exactly one cycle; readdata = DEADBEEF. Load from 0x00020000 → readdata = 0.
- GPIO: write 32'h0000_00A5 to FFFF0000 → gpio_out = A5 on the next cycle; read returns A5. Assert reset mid-way → gpio_out = 0 immediately.
- Timer (TIMER_DIV=1):
  - Write TCMP = 10, TCOUNT = 0 → irq rises 10 cycles later; STATUS read = 32'h5.
  - Write 1 to STATUS bit0 → irq = 0.
  - Write TCOUNT = FFFF_FFFF → TCOUNT = 0 on the next cycle.
- FIFO fill (FIFO_DEPTH=4, tx_ready=0): push bytes 0x11, 0x22, 0x33, 0x44, 0x55 → STATUS bit1 and bit3 = 1; TXDATA read = 4. Then set tx_ready=1 → tx_data sequence is 11, 22, 33, 44 and 0x55 never appears.
- Full push with simultaneous pop: with the FIFO full, push 0x66 while tx_ready=1 → accepted, count stays 4, overflow stays 0.
- Build without MMIO_TIMER_EN: write TCOUNT = 5 → read returns 0; irq stays 0 for 100 cycles.
